// File: rtl/input_tile_mem.sv
// input_tile_mem: on-chip store of 6x6 int8 input tiles, row-serial load port plus two tile read ports.
// Latency: a read request returns both tiles one cycle later; a load writes one row per accepted beat.
// Backpressure: ld_ready_o is high only while loading; read requests made during a load are dropped.
module input_tile_mem #(
  parameter int DEPTH     = 255,  // tile slots, addresses 0..DEPTH-1 (DEPTH <= 255)
  parameter int NULL_ADDR = 255   // sentinel address that always reads as an all-zero tile
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ld_start_i,
  input  logic [7:0]           ld_base_i,
  input  logic [7:0]           ld_num_tiles_i,
  input  logic [5:0][7:0]      ld_row_i,
  input  logic                 ld_valid_i,
  output logic                 ld_ready_o,
  output logic                 ld_done_o,
  output logic                 busy_o,
  input  logic [7:0]           rd_addr_i_1,
  input  logic [7:0]           rd_addr_i_2,
  input  logic                 rd_request_i,
  output logic [5:0][5:0][7:0] rd_data_o_1,
  output logic [5:0][5:0][7:0] rd_data_o_2,
  output logic                 rd_valid_o
);

  localparam logic [7:0] LAST_ADDR = 8'(DEPTH - 1);
  localparam logic [7:0] NULL_A    = 8'(NULL_ADDR);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t          r_state;
  logic [2:0]      r_row_cnt;
  logic [7:0]      r_tile_ptr;
  logic [7:0]      r_tiles_left;

  // Tile storage, one packed row per entry; deliberately left out of reset.
  logic [5:0][7:0] r_mem [DEPTH][6];

  logic                 w_wr_fire;
  logic                 w_wr_in_range;
  logic                 w_rd_ok_1;
  logic                 w_rd_ok_2;
  logic                 w_rd_serve;
  logic [5:0][5:0][7:0] w_tile_1;
  logic [5:0][5:0][7:0] w_tile_2;

  // ld_ready_o is a registered copy of "state is LOAD", so it qualifies the beat directly.
  assign w_wr_fire     = ld_valid_i && ld_ready_o;
  // An out-of-range base still advances the counters; only the array write is suppressed.
  assign w_wr_in_range = (r_tile_ptr <= LAST_ADDR);
  assign w_rd_ok_1     = (rd_addr_i_1 != NULL_A) && (rd_addr_i_1 <= LAST_ADDR);
  assign w_rd_ok_2     = (rd_addr_i_2 != NULL_A) && (rd_addr_i_2 <= LAST_ADDR);
  // Reads are only served when no load is in flight, including the cycle of the final row write.
  assign w_rd_serve    = rd_request_i && (r_state == IDLE);

  // Gather the six rows of each addressed tile; invalid addresses yield a zero tile.
  always_comb begin
    w_tile_1 = '0;
    w_tile_2 = '0;
    for (int r = 0; r < 6; r++) begin
      if (w_rd_ok_1) w_tile_1[r] = r_mem[rd_addr_i_1][r];
      if (w_rd_ok_2) w_tile_2[r] = r_mem[rd_addr_i_2][r];
    end
  end

  // Load sequencer: tracks row/tile position, drives ready/busy/done as registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_row_cnt    <= 3'd0;
      r_tile_ptr   <= 8'd0;
      r_tiles_left <= 8'd0;
      ld_ready_o   <= 1'b0;
      ld_done_o    <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      ld_done_o <= 1'b0;
      case (r_state)
        IDLE: begin
          if (ld_start_i) begin
            if (ld_num_tiles_i != 8'd0) begin
              r_state      <= LOAD;
              r_tile_ptr   <= ld_base_i;
              r_tiles_left <= ld_num_tiles_i;
              r_row_cnt    <= 3'd0;
              ld_ready_o   <= 1'b1;
              busy_o       <= 1'b1;
            end else begin
              // Empty load completes immediately without touching the array.
              ld_done_o <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (w_wr_fire) begin
            if (r_row_cnt == 3'd5) begin
              r_row_cnt    <= 3'd0;
              r_tile_ptr   <= (r_tile_ptr == LAST_ADDR) ? 8'd0 : r_tile_ptr + 8'd1;
              r_tiles_left <= r_tiles_left - 8'd1;
              if (r_tiles_left == 8'd1) begin
                r_state    <= IDLE;
                ld_ready_o <= 1'b0;
                busy_o     <= 1'b0;
                ld_done_o  <= 1'b1;
              end
            end else begin
              r_row_cnt <= r_row_cnt + 3'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Array write port: one row per accepted load beat.
  always_ff @(posedge clk) begin
    if (w_wr_fire && w_wr_in_range) begin
      r_mem[r_tile_ptr][r_row_cnt] <= ld_row_i;
    end
  end

  // Read response register: one tile pair per request, zeros when not served.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_o  <= 1'b0;
      rd_data_o_1 <= '0;
      rd_data_o_2 <= '0;
    end else begin
      rd_valid_o  <= w_rd_serve;
      rd_data_o_1 <= w_rd_serve ? w_tile_1 : '0;
      rd_data_o_2 <= w_rd_serve ? w_tile_2 : '0;
    end
  end

endmodule

// File: tb/tb_input_tile_mem.sv
// Testbench for input_tile_mem: fills every tile through the load port, then checks reads,
// load corner cases (wrap, bubbles, empty load, reset mid-load) and random traffic against a tile model.
`timescale 1ns/1ps
module tb_input_tile_mem;

  typedef logic [5:0][5:0][7:0] tile_t;
  typedef logic [5:0][7:0]      row_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ld_start_i = 1'b0;
  logic [7:0]  ld_base_i = '0;
  logic [7:0]  ld_num_tiles_i = '0;
  row_t        ld_row_i = '0;
  logic        ld_valid_i = 1'b0;
  logic        ld_ready_o;
  logic        ld_done_o;
  logic        busy_o;
  logic [7:0]  rd_addr_i_1 = '0;
  logic [7:0]  rd_addr_i_2 = '0;
  logic        rd_request_i = 1'b0;
  tile_t       rd_data_o_1;
  tile_t       rd_data_o_2;
  logic        rd_valid_o;

  always #5 clk = ~clk;

  input_tile_mem dut (
    .clk(clk), .reset(reset),
    .ld_start_i(ld_start_i), .ld_base_i(ld_base_i), .ld_num_tiles_i(ld_num_tiles_i),
    .ld_row_i(ld_row_i), .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o),
    .ld_done_o(ld_done_o), .busy_o(busy_o),
    .rd_addr_i_1(rd_addr_i_1), .rd_addr_i_2(rd_addr_i_2), .rd_request_i(rd_request_i),
    .rd_data_o_1(rd_data_o_1), .rd_data_o_2(rd_data_o_2), .rd_valid_o(rd_valid_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference contents: model[t][r] is row r of tile t. Tile 255 is never a real slot.
  row_t model [256][6];

  function automatic tile_t exp_tile(input logic [7:0] a);
    tile_t t;
    t = '0;
    if (a < 8'd255) begin
      for (int r = 0; r < 6; r++) t[r] = model[a][r];
    end
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_tile(input string name, input tile_t act, input tile_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one read request and compare the response one cycle later.
  task automatic read_pair(input string name, input logic [7:0] a1, input logic [7:0] a2);
    rd_addr_i_1  = a1;
    rd_addr_i_2  = a2;
    rd_request_i = 1'b1;
    step();
    rd_request_i = 1'b0;
    chk({name, "_vld"}, 32'(rd_valid_o), 32'd1);
    chk_tile({name, "_t1"}, rd_data_o_1, exp_tile(a1));
    chk_tile({name, "_t2"}, rd_data_o_2, exp_tile(a2));
  endtask

  // mode 0: valid every cycle, 1: random bubbles, 2: alternate 1/0.
  // pat: row[c] = t*100 + r*10 + c for the t-th tile of this load; otherwise random data.
  // hold_req: keep rd_request_i high for the whole load and check it is held off.
  task automatic do_load(input logic [7:0] base, input logic [7:0] num, input int mode,
                         input bit pat, input bit hold_req);
    logic [7:0] ptr;
    int row, t, writes, cyc, n;
    bit v;
    ptr = base; row = 0; t = 0; writes = 0; cyc = 0; n = int'(num) * 6;
    ld_base_i = base;
    ld_num_tiles_i = num;
    ld_start_i = 1'b1;
    step();
    ld_start_i = 1'b0;
    chk("busy_after_start", 32'(busy_o), 32'd1);
    if (hold_req) rd_request_i = 1'b1;
    while (writes < n && cyc < 8 * n + 16) begin
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) v = 1'($urandom_range(0, 1));
      else                v = (cyc % 2 == 0);
      for (int c = 0; c < 6; c++)
        ld_row_i[c] = pat ? 8'(t * 100 + row * 10 + c) : 8'($urandom);
      ld_valid_i = v;
      chk("ld_ready_in_load", 32'(ld_ready_o), 32'd1);
      chk("ld_done_low_in_load", 32'(ld_done_o), 32'd0);
      step();
      cyc++;
      if (hold_req) chk("rd_blocked_in_load", 32'(rd_valid_o), 32'd0);
      if (v) begin
        if (ptr < 8'd255) model[ptr][row] = ld_row_i;
        writes++;
        if (row == 5) begin
          row = 0;
          t++;
          ptr = (ptr == 8'd254) ? 8'd0 : ptr + 8'd1;
        end else begin
          row++;
        end
      end
    end
    ld_valid_i = 1'b0;
    chk("load_writes", 32'(writes), 32'(n));
    chk("ld_done_pulse", 32'(ld_done_o), 32'd1);
    chk("busy_cleared", 32'(busy_o), 32'd0);
    chk("ready_cleared", 32'(ld_ready_o), 32'd0);
    step();
    chk("ld_done_one_cycle", 32'(ld_done_o), 32'd0);
    if (hold_req) begin
      chk("rd_served_after_load", 32'(rd_valid_o), 32'd1);
      chk_tile("rd_after_load_t1", rd_data_o_1, exp_tile(rd_addr_i_1));
      chk_tile("rd_after_load_t2", rd_data_o_2, exp_tile(rd_addr_i_2));
      rd_request_i = 1'b0;
    end
  endtask

  typedef struct {
    logic [7:0] a1;
    logic [7:0] a2;
    logic       req;
    logic       exp_vld;
    logic       zero1;
    logic       zero2;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vecs [8];
    tile_t e1, e2;
    logic [7:0] a1, a2;
    bit req;

    // ---- reset state ----
    #2 reset = 1'b1;
    step();
    step();
    chk("rst_ready", 32'(ld_ready_o), 32'd0);
    chk("rst_done", 32'(ld_done_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_vld", 32'(rd_valid_o), 32'd0);
    chk_tile("rst_d1", rd_data_o_1, '0);
    chk_tile("rst_d2", rd_data_o_2, '0);
    reset = 1'b0;
    step();

    // ---- fill every slot with random data, random bubbles ----
    do_load(8'd0, 8'd255, 1, 1'b0, 1'b0);

    // ---- pattern load base 0, two tiles; check against the closed-form values ----
    do_load(8'd0, 8'd2, 0, 1'b1, 1'b0);
    rd_addr_i_1 = 8'd0; rd_addr_i_2 = 8'd1; rd_request_i = 1'b1;
    step();
    rd_request_i = 1'b0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) begin
        e1[r][c] = 8'(r * 10 + c);
        e2[r][c] = 8'(100 + r * 10 + c);
      end
    chk("pat_vld", 32'(rd_valid_o), 32'd1);
    chk_tile("pat_tile0", rd_data_o_1, e1);
    chk_tile("pat_tile1", rd_data_o_2, e2);

    // ---- table-driven back-to-back reads ----
    vecs[0] = '{8'd0,   8'd1,   1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'd4,   8'hFF,  1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{8'd7,   8'd7,   1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'hFF,  8'd254, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'd3,   8'd9,   1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{8'd254, 8'd0,   1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'hFF,  8'hFF,  1'b1, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{8'd128, 8'd127, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      rd_addr_i_1  = vecs[i].a1;
      rd_addr_i_2  = vecs[i].a2;
      rd_request_i = vecs[i].req;
      step();
      chk($sformatf("vec%0d_vld", i), 32'(rd_valid_o), 32'(vecs[i].exp_vld));
      chk_tile($sformatf("vec%0d_t1", i), rd_data_o_1,
               (vecs[i].exp_vld && !vecs[i].zero1) ? exp_tile(vecs[i].a1) : tile_t'('0));
      chk_tile($sformatf("vec%0d_t2", i), rd_data_o_2,
               (vecs[i].exp_vld && !vecs[i].zero2) ? exp_tile(vecs[i].a2) : tile_t'('0));
    end
    rd_request_i = 1'b0;
    step();

    // ---- wrap 254 -> 0 with toggling valid, read request held through the load ----
    rd_addr_i_1 = 8'd254;
    rd_addr_i_2 = 8'd0;
    do_load(8'd254, 8'd2, 2, 1'b0, 1'b1);
    read_pair("wrap_rd", 8'd254, 8'd0);

    // ---- empty load: done next cycle, never busy, memory unchanged ----
    ld_base_i = 8'd5; ld_num_tiles_i = 8'd0; ld_start_i = 1'b1;
    step();
    ld_start_i = 1'b0;
    chk("empty_done", 32'(ld_done_o), 32'd1);
    chk("empty_busy", 32'(busy_o), 32'd0);
    chk("empty_ready", 32'(ld_ready_o), 32'd0);
    step();
    chk("empty_done_clear", 32'(ld_done_o), 32'd0);
    chk("empty_busy2", 32'(busy_o), 32'd0);
    read_pair("empty_rd", 8'd5, 8'd6);

    // ---- reset after three rows of a load ----
    ld_base_i = 8'd10; ld_num_tiles_i = 8'd3; ld_start_i = 1'b1;
    step();
    ld_start_i = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 6; c++) ld_row_i[c] = 8'($urandom);
      ld_valid_i = 1'b1;
      step();
      model[10][r] = ld_row_i;
    end
    ld_valid_i = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_ready", 32'(ld_ready_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_done", 32'(ld_done_o), 32'd0);
    chk("midrst_vld", 32'(rd_valid_o), 32'd0);
    step();
    reset = 1'b0;
    step();
    read_pair("midrst_rd", 8'd10, 8'd11);
    do_load(8'd10, 8'd1, 1, 1'b0, 1'b0);
    read_pair("reload_rd", 8'd10, 8'd9);

    // ---- random traffic against the model ----
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        do_load(8'($urandom_range(0, 255)), 8'($urandom_range(1, 3)), 1, 1'b0, 1'b0);
      end else begin
        a1  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
        a2  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
        req = 1'($urandom_range(0, 3) != 0);
        rd_addr_i_1 = a1;
        rd_addr_i_2 = a2;
        rd_request_i = req;
        step();
        chk("rand_vld", 32'(rd_valid_o), 32'(req));
        chk_tile("rand_t1", rd_data_o_1, req ? exp_tile(a1) : tile_t'('0));
        chk_tile("rand_t2", rd_data_o_2, req ? exp_tile(a2) : tile_t'('0));
        rd_request_i = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
